uart_buffered: RTL and testbench
================================

// Module: uart_buffered
// PURPOSE
//  Next-generation UART: a buffered, parametrised successor to the plain uart top.
//  Contains a baud tick generator (16x oversampling), RX and TX serial engines,
//  optional parity, and one FIFO per direction.
//  RX reports framing, parity and overrun errors. Sits between the pins and the
//  processor/interface logic, so software-side producers never wait per byte.
// PARAMETERS
//  NB_DATA    8         data bits per frame (5..9)
//  SB_TICK    16        oversample ticks in stop period (16=1 stop, 32=2 stop)
//  PARITY     0         0 none, 1 even, 2 odd
//  FIFO_AW    4         FIFO address width; depth = 2**FIFO_AW per direction
//  CLK_FREC   50000000  clock frequency, Hz
//  BAUD_RATE  9600      line rate; DIV = CLK_FREC/(BAUD_RATE*16), integer, >=2
// PORTS
//  i_clk          in   1        clock
//  i_reset        in   1        synchronous, active-low reset
//  i_rx           in   1        serial input (idle high), pre-synchronised by 2 FFs here
//  o_tx           out  1        serial output (idle high)
//  i_tx_wr        in   1        push i_tx_data into TX FIFO
//  i_tx_data      in   NB_DATA  TX word
//  o_tx_full      out  1        TX FIFO full
//  o_tx_empty     out  1        TX FIFO empty
//  o_tx_done_tick out  1        1-cycle pulse at end of each transmitted stop period
//  i_rx_rd        in   1        pop RX FIFO head
//  o_rx_data      out  NB_DATA  RX FIFO head (first-word-fall-through)
//  o_rx_empty     out  1        RX FIFO empty
//  o_rx_full      out  1        RX FIFO full
//  o_rx_overrun   out  1        sticky: word received while RX FIFO full (word dropped)
//  o_parity_err   out  1        sticky: parity mismatch on any received word
//  o_frame_err    out  1        sticky: stop bit sampled low
//  i_clr_err      in   1        clears all three sticky flags (set has priority same cycle)
// BEHAVIOUR
//  Reset (i_reset=0 at edge): FIFOs emptied, FSMs IDLE, tick counter 0, o_tx=1,
//   all flags/pulses 0, o_rx_data=0. Reset mid-frame aborts the frame; no partial push.
//  Tick: counter 0..DIV-1; tick=1 for one cycle when counter==DIV-1, then wraps to 0.
//  RX FSM IDLE->START->DATA->(PARITY)->STOP->IDLE, tick counter s, bit counter n:
//   IDLE: synced rx==0 -> START, s=0.
//   START: at s==7 re-sample; 0 -> DATA, s=0; 1 -> IDLE (glitch, nothing pushed).
//   DATA: at s==15 shift in LSB-first; after NB_DATA bits -> PARITY if PARITY!=0 else STOP.
//   PARITY: at s==15 check XOR(data,bit) (==0 even / ==1 odd); mismatch sets o_parity_err.
//   STOP: at s==SB_TICK-1 sample; 0 sets o_frame_err; word pushed to RX FIFO
//   (even if errored); if FIFO full, word dropped and o_rx_overrun set; -> IDLE.
//  TX FSM same states. IDLE: FIFO non-empty and tick -> pop head, START.
//   START/DATA/PARITY: 16 ticks per bit, data LSB-first; parity bit = ^data (even) or
//   ~^data (odd). STOP: o_tx=1 for SB_TICK ticks; last tick pulses o_tx_done_tick;
//   -> IDLE; back-to-back frames when FIFO non-empty. o_tx is registered.
//  FIFO rules (both): write when full ignored; read when empty ignored;
//   rd&wr when full -> both happen, count unchanged;
//   rd&wr when empty -> write only. Pointers wrap mod 2**FIFO_AW.
//   full/empty are registered and exact.
//   A push is visible on o_rx_data / o_*_empty the cycle after the write edge.
// STRUCTURE
//  uart_pkg: PARITY_NONE/EVEN/ODD constants, FSM state encodings (3-bit), OVERSAMPLE=16.
//  Sub-module uart_fifo (NB_DATA, FIFO_AW), instantiated twice (TX, RX).
//  Tick generator, RX and TX FSMs are inline in this file.
// TESTING (bench: CLK_FREC=1600000, BAUD_RATE=10000 -> DIV=10, bit=160 clk)
//  o_tx looped to i_rx, PARITY=1; write 0xA5 -> o_rx_data=0xA5, o_rx_empty=0, no flags;
//   o_tx_done_tick exactly once, 11*160 clk after start.
//  FIFO_AW=2, no reads; loop 5 words 0x01..0x05 -> RX FIFO holds 0x01..0x04;
//   o_rx_full=1, o_rx_overrun=1; i_clr_err -> 0.
//  Drive frame 0x3C with stop bit low -> word pushed as 0x3C, o_frame_err=1.
//  PARITY=2; drive 0x0F with parity bit 0 -> o_parity_err=1, data 0x0F.
//  i_rx low pulse of 50 clk (<8 ticks) -> no push, FSM back to IDLE, no flags.
//  Write 3 words, assert reset mid-second frame -> o_tx=1 next cycle, TX empty,
//   no done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and oversample rate.
// Latency: none, constants and types only.
// Backpressure: none, imported by the UART datapath.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   localparam int OVERSAMPLE  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO, first-word-fall-through, registered exact full/empty.
// Latency: a write is visible on rd_data/empty the cycle after the write edge.
// Backpressure: write when full ignored unless a read happens in the same cycle; read when empty ignored.
module uart_fifo #(
   parameter int NB_DATA = 8,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr,
   input  logic [NB_DATA-1:0] wr_data,
   input  logic               rd,
   output logic [NB_DATA-1:0] rd_data,
   output logic               full,
   output logic               empty
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
   localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
   localparam logic [FIFO_AW:0]   CNT_LAST = (FIFO_AW + 1)'(DEPTH - 1);

   logic [NB_DATA-1:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               wr_en;
   logic               rd_en;

   // A full FIFO still accepts a write when a read frees the slot in the same cycle.
   assign rd_en = rd && !empty;
   assign wr_en = wr && (!full || rd);

   // Storage array, no reset needed since empty masks stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer, occupancy and flag update; flags derive from the pre-update count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (wr_en && !rd_en) begin
            count <= count + CNT_ONE;
            full  <= (count == CNT_LAST);
            empty <= 1'b0;
         end else if (rd_en && !wr_en) begin
            count <= count - CNT_ONE;
            full  <= 1'b0;
            empty <= (count == CNT_ONE);
         end
      end
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: 16x baud tick, RX/TX serial engines with optional parity, one FIFO per direction.
// Latency: one frame per word each way; received word visible the cycle after its mid-stop sample.
// Backpressure: TX writes dropped when TX FIFO full; RX words dropped (overrun flagged) when RX FIFO full.
module uart_buffered
   import uart_pkg::*;
#(
   parameter int NB_DATA   = 8,
   parameter int SB_TICK   = 16,
   parameter int PARITY    = 0,
   parameter int FIFO_AW   = 4,
   parameter int CLK_FREC  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   output logic               o_tx,
   input  logic               i_tx_wr,
   input  logic [NB_DATA-1:0] i_tx_data,
   output logic               o_tx_full,
   output logic               o_tx_empty,
   output logic               o_tx_done_tick,
   input  logic               i_rx_rd,
   output logic [NB_DATA-1:0] o_rx_data,
   output logic               o_rx_empty,
   output logic               o_rx_full,
   output logic               o_rx_overrun,
   output logic               o_parity_err,
   output logic               o_frame_err,
   input  logic               i_clr_err
);

   localparam int DIV   = CLK_FREC / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = 1;

   localparam logic [4:0] S_ONE  = 5'd1;
   localparam logic [4:0] S_MID  = 5'(OVERSAMPLE / 2 - 1);
   localparam logic [4:0] S_BIT  = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
   localparam logic [3:0] N_ONE  = 4'd1;
   localparam logic [3:0] N_LAST = 4'(NB_DATA - 1);

   localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
   localparam logic ODD_PAR    = (PARITY == PARITY_ODD);

   logic [DIV_W-1:0] tick_cnt;
   logic             tick;
   logic             rx_meta;
   logic             rx_sync;

   uart_state_t        rx_state, rx_state_nx;
   logic [4:0]         rx_s, rx_s_nx;
   logic [3:0]         rx_n, rx_n_nx;
   logic [NB_DATA-1:0] rx_b, rx_b_nx;
   logic               rx_push, rx_perr_set, rx_ferr_set, rx_ovr_set;
   logic               rx_fifo_full;

   uart_state_t        tx_state, tx_state_nx;
   logic [4:0]         tx_s, tx_s_nx;
   logic [3:0]         tx_n, tx_n_nx;
   logic [NB_DATA-1:0] tx_b, tx_b_nx;
   logic               tx_par, tx_par_nx;
   logic               tx_line, tx_line_nx;
   logic               tx_done, tx_done_nx;
   logic               tx_pop;
   logic               tx_fifo_empty;
   logic [NB_DATA-1:0] tx_fifo_data;

   // Oversample tick: one-cycle pulse every DIV clocks.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + DIV_ONE;
      end
   end

   assign tick = (tick_cnt == DIV_LAST);

   // Two-flop synchroniser on the asynchronous serial input, idle high.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   // RX state register and datapath; reset aborts any frame in flight.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         rx_state <= ST_IDLE;
         rx_s     <= '0;
         rx_n     <= '0;
         rx_b     <= '0;
      end else begin
         rx_state <= rx_state_nx;
         rx_s     <= rx_s_nx;
         rx_n     <= rx_n_nx;
         rx_b     <= rx_b_nx;
      end
   end

   // RX next state: mid-bit sampling, LSB-first shift, parity check, stop sample and push.
   always_comb begin
      rx_state_nx = rx_state;
      rx_s_nx     = rx_s;
      rx_n_nx     = rx_n;
      rx_b_nx     = rx_b;
      rx_push     = 1'b0;
      rx_perr_set = 1'b0;
      rx_ferr_set = 1'b0;
      case (rx_state)
         ST_IDLE: begin
            if (!rx_sync) begin
               rx_state_nx = ST_START;
               rx_s_nx     = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rx_s == S_MID) begin
                  rx_s_nx     = '0;
                  rx_n_nx     = '0;
                  rx_state_nx = rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  rx_s_nx = rx_s + S_ONE;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (rx_s == S_BIT) begin
                  rx_s_nx = '0;
                  rx_b_nx = {rx_sync, rx_b[NB_DATA-1:1]};
                  if (rx_n == N_LAST) begin
                     rx_state_nx = HAS_PARITY ? ST_PARITY : ST_STOP;
                  end else begin
                     rx_n_nx = rx_n + N_ONE;
                  end
               end else begin
                  rx_s_nx = rx_s + S_ONE;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               if (rx_s == S_BIT) begin
                  rx_s_nx     = '0;
                  rx_perr_set = (((^rx_b) ^ rx_sync) != ODD_PAR);
                  rx_state_nx = ST_STOP;
               end else begin
                  rx_s_nx = rx_s + S_ONE;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (rx_s == S_STOP) begin
                  rx_push     = 1'b1;
                  rx_ferr_set = !rx_sync;
                  rx_state_nx = ST_IDLE;
               end else begin
                  rx_s_nx = rx_s + S_ONE;
               end
            end
         end
         default: rx_state_nx = ST_IDLE;
      endcase
   end

   // A push into a full FIFO is only lost if no read frees a slot that cycle.
   assign rx_ovr_set = rx_push && rx_fifo_full && !i_rx_rd;

   // Sticky error flags; a new error wins over a clear in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_rx_overrun <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         if (rx_ovr_set) begin
            o_rx_overrun <= 1'b1;
         end else if (i_clr_err) begin
            o_rx_overrun <= 1'b0;
         end
         if (rx_perr_set) begin
            o_parity_err <= 1'b1;
         end else if (i_clr_err) begin
            o_parity_err <= 1'b0;
         end
         if (rx_ferr_set) begin
            o_frame_err <= 1'b1;
         end else if (i_clr_err) begin
            o_frame_err <= 1'b0;
         end
      end
   end

   // TX state register, registered line output and done pulse.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         tx_state <= ST_IDLE;
         tx_s     <= '0;
         tx_n     <= '0;
         tx_b     <= '0;
         tx_par   <= 1'b0;
         tx_line  <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         tx_state <= tx_state_nx;
         tx_s     <= tx_s_nx;
         tx_n     <= tx_n_nx;
         tx_b     <= tx_b_nx;
         tx_par   <= tx_par_nx;
         tx_line  <= tx_line_nx;
         tx_done  <= tx_done_nx;
      end
   end

   // TX next state: pop on a tick, 16 ticks per bit, line level follows the state being entered.
   always_comb begin
      tx_state_nx = tx_state;
      tx_s_nx     = tx_s;
      tx_n_nx     = tx_n;
      tx_b_nx     = tx_b;
      tx_par_nx   = tx_par;
      tx_done_nx  = 1'b0;
      tx_pop      = 1'b0;
      tx_line_nx  = 1'b1;
      case (tx_state)
         ST_IDLE: begin
            if (tick && !tx_fifo_empty) begin
               tx_pop      = 1'b1;
               tx_b_nx     = tx_fifo_data;
               tx_par_nx   = (^tx_fifo_data) ^ ODD_PAR;
               tx_s_nx     = '0;
               tx_state_nx = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (tx_s == S_BIT) begin
                  tx_s_nx     = '0;
                  tx_n_nx     = '0;
                  tx_state_nx = ST_DATA;
               end else begin
                  tx_s_nx = tx_s + S_ONE;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (tx_s == S_BIT) begin
                  tx_s_nx = '0;
                  tx_b_nx = tx_b >> 1;
                  if (tx_n == N_LAST) begin
                     tx_state_nx = HAS_PARITY ? ST_PARITY : ST_STOP;
                  end else begin
                     tx_n_nx = tx_n + N_ONE;
                  end
               end else begin
                  tx_s_nx = tx_s + S_ONE;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               if (tx_s == S_BIT) begin
                  tx_s_nx     = '0;
                  tx_state_nx = ST_STOP;
               end else begin
                  tx_s_nx = tx_s + S_ONE;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (tx_s == S_STOP) begin
                  tx_done_nx  = 1'b1;
                  tx_state_nx = ST_IDLE;
               end else begin
                  tx_s_nx = tx_s + S_ONE;
               end
            end
         end
         default: tx_state_nx = ST_IDLE;
      endcase
      case (tx_state_nx)
         ST_START:  tx_line_nx = 1'b0;
         ST_DATA:   tx_line_nx = tx_b_nx[0];
         ST_PARITY: tx_line_nx = tx_par_nx;
         default:   tx_line_nx = 1'b1;
      endcase
   end

   assign o_tx           = tx_line;
   assign o_tx_done_tick = tx_done;
   assign o_tx_empty     = tx_fifo_empty;
   assign o_rx_full      = rx_fifo_full;

   uart_fifo #(
      .NB_DATA (NB_DATA),
      .FIFO_AW (FIFO_AW)
   ) u_tx_fifo (
      .clk     (i_clk),
      .rst_n   (i_reset),
      .wr      (i_tx_wr),
      .wr_data (i_tx_data),
      .rd      (tx_pop),
      .rd_data (tx_fifo_data),
      .full    (o_tx_full),
      .empty   (tx_fifo_empty)
   );

   uart_fifo #(
      .NB_DATA (NB_DATA),
      .FIFO_AW (FIFO_AW)
   ) u_rx_fifo (
      .clk     (i_clk),
      .rst_n   (i_reset),
      .wr      (rx_push),
      .wr_data (rx_b),
      .rd      (i_rx_rd),
      .rd_data (o_rx_data),
      .full    (rx_fifo_full),
      .empty   (o_rx_empty)
   );

endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: looped-back even-parity instance (A) and a bench-driven odd-parity RX instance (B).
// Each test task drives stimulus and compares against values derived from frame rules.
// Counts comparisons and failures, prints one summary line.
`timescale 1ns/1ps
module tb_uart_buffered;

   localparam int BIT_CLK = 160;
   localparam int DEPTH_A = 4;

   logic clk;
   logic rst_n;

   logic       a_tx, a_tx_wr, a_tx_full, a_tx_empty, a_done;
   logic [7:0] a_tx_data, a_rx_data;
   logic       a_rx_rd, a_rx_empty, a_rx_full, a_ovr, a_perr, a_ferr, a_clr;

   logic       b_rx, b_tx, b_tx_wr, b_tx_full, b_tx_empty, b_done;
   logic [7:0] b_tx_data, b_rx_data;
   logic       b_rx_rd, b_rx_empty, b_rx_full, b_ovr, b_perr, b_ferr, b_clr;

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_buffered #(
      .NB_DATA(8), .SB_TICK(16), .PARITY(1), .FIFO_AW(2),
      .CLK_FREC(1600000), .BAUD_RATE(10000)
   ) dut_a (
      .i_clk(clk), .i_reset(rst_n), .i_rx(a_tx), .o_tx(a_tx),
      .i_tx_wr(a_tx_wr), .i_tx_data(a_tx_data), .o_tx_full(a_tx_full),
      .o_tx_empty(a_tx_empty), .o_tx_done_tick(a_done),
      .i_rx_rd(a_rx_rd), .o_rx_data(a_rx_data), .o_rx_empty(a_rx_empty),
      .o_rx_full(a_rx_full), .o_rx_overrun(a_ovr), .o_parity_err(a_perr),
      .o_frame_err(a_ferr), .i_clr_err(a_clr)
   );

   uart_buffered #(
      .NB_DATA(8), .SB_TICK(16), .PARITY(2), .FIFO_AW(4),
      .CLK_FREC(1600000), .BAUD_RATE(10000)
   ) dut_b (
      .i_clk(clk), .i_reset(rst_n), .i_rx(b_rx), .o_tx(b_tx),
      .i_tx_wr(b_tx_wr), .i_tx_data(b_tx_data), .o_tx_full(b_tx_full),
      .o_tx_empty(b_tx_empty), .o_tx_done_tick(b_done),
      .i_rx_rd(b_rx_rd), .o_rx_data(b_rx_data), .o_rx_empty(b_rx_empty),
      .o_rx_full(b_rx_full), .o_rx_overrun(b_ovr), .o_parity_err(b_perr),
      .o_frame_err(b_ferr), .i_clr_err(b_clr)
   );

   // Odd parity bit: total number of ones including the bit is odd.
   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic write_a(input logic [7:0] d);
      @(negedge clk);
      a_tx_data = d;
      a_tx_wr   = 1'b1;
      @(negedge clk);
      a_tx_wr   = 1'b0;
   endtask

   task automatic pop_a();
      @(negedge clk); a_rx_rd = 1'b1;
      @(negedge clk); a_rx_rd = 1'b0;
   endtask

   task automatic clr_a();
      @(negedge clk); a_clr = 1'b1;
      @(negedge clk); a_clr = 1'b0;
   endtask

   task automatic pop_b();
      @(negedge clk); b_rx_rd = 1'b1;
      @(negedge clk); b_rx_rd = 1'b0;
   endtask

   task automatic clr_b();
      @(negedge clk); b_clr = 1'b1;
      @(negedge clk); b_clr = 1'b0;
   endtask

   // Serial frame into instance B; a bad stop bit is held low 120 clk then released.
   task automatic drive_frame(input logic [7:0] d, input logic pbit, input logic stop_ok);
      @(negedge clk); b_rx = 1'b0;
      repeat (BIT_CLK - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         b_rx = d[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      b_rx = pbit;
      repeat (BIT_CLK) @(negedge clk);
      if (stop_ok) begin
         b_rx = 1'b1;
         repeat (BIT_CLK) @(negedge clk);
      end else begin
         b_rx = 1'b0;
         repeat (120) @(negedge clk);
         b_rx = 1'b1;
         repeat (40) @(negedge clk);
      end
      repeat (240) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [8:0] got;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      got = {a_tx, a_tx_empty, a_tx_full, a_done, a_rx_empty, a_rx_full, a_ovr, a_perr, a_ferr};
      n_checks++;
      if (got !== 9'b110010000) begin
         n_fail++; $display("FAIL reset_a_flags: got %b want %b", got, 9'b110010000);
      end
      got = {b_tx, b_tx_empty, b_tx_full, b_done, b_rx_empty, b_rx_full, b_ovr, b_perr, b_ferr};
      n_checks++;
      if (got !== 9'b110010000) begin
         n_fail++; $display("FAIL reset_b_flags: got %b want %b", got, 9'b110010000);
      end
      n_checks++;
      if (a_rx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rx_data: got %h want 00", a_rx_data);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_loopback();
      int fall_cyc, done_cyc, done_cnt;
      fall_cyc = -1; done_cyc = -1; done_cnt = 0;
      write_a(8'hA5);
      for (int c = 0; c < 2200; c++) begin
         @(negedge clk);
         if (fall_cyc < 0 && a_tx === 1'b0) fall_cyc = c;
         if (a_done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL loop_done_count: got %0d want 1", done_cnt);
      end
      n_checks++;
      if (fall_cyc < 0 || done_cyc - fall_cyc != 11 * BIT_CLK) begin
         n_fail++; $display("FAIL loop_done_time: got %0d want %0d", done_cyc - fall_cyc, 11 * BIT_CLK);
      end
      n_checks++;
      if (a_rx_empty !== 1'b0 || a_rx_data !== 8'hA5) begin
         n_fail++; $display("FAIL loop_data: got empty=%b data=%h want empty=0 data=a5", a_rx_empty, a_rx_data);
      end
      n_checks++;
      if ({a_ovr, a_perr, a_ferr} !== 3'b000) begin
         n_fail++; $display("FAIL loop_flags: got %b want 000", {a_ovr, a_perr, a_ferr});
      end
      pop_a();
      n_checks++;
      if (a_rx_empty !== 1'b1) begin
         n_fail++; $display("FAIL loop_pop_empty: got %b want 1", a_rx_empty);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] exp_q[$];
      logic       exp_ovr;
      int         done_cnt;
      exp_q = {};
      exp_ovr = 1'b0;
      for (int w = 1; w <= 5; w++) begin
         for (int c = 0; c < 3000 && a_tx_full; c++) @(negedge clk);
         write_a(8'(w));
         if (exp_q.size() < DEPTH_A) exp_q.push_back(8'(w));
         else exp_ovr = 1'b1;
      end
      done_cnt = 0;
      for (int c = 0; c < 12000 && done_cnt < 5; c++) begin
         @(negedge clk);
         if (a_done === 1'b1) done_cnt++;
      end
      n_checks++;
      if (done_cnt != 5) begin
         n_fail++; $display("FAIL ovr_frames_sent: got %0d want 5", done_cnt);
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (a_rx_full !== (exp_q.size() == DEPTH_A)) begin
         n_fail++; $display("FAIL ovr_rx_full: got %b want %b", a_rx_full, exp_q.size() == DEPTH_A);
      end
      n_checks++;
      if (a_ovr !== exp_ovr) begin
         n_fail++; $display("FAIL ovr_flag: got %b want %b", a_ovr, exp_ovr);
      end
      clr_a();
      n_checks++;
      if (a_ovr !== 1'b0 || a_rx_full !== 1'b1) begin
         n_fail++; $display("FAIL ovr_clear: got ovr=%b full=%b want ovr=0 full=1", a_ovr, a_rx_full);
      end
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_checks++;
         if (a_rx_data !== e || a_rx_empty !== 1'b0) begin
            n_fail++; $display("FAIL ovr_fifo_word: got %h empty=%b want %h", a_rx_data, a_rx_empty, e);
         end
         pop_a();
      end
      n_checks++;
      if (a_rx_empty !== 1'b1) begin
         n_fail++; $display("FAIL ovr_drained: got empty=%b want 1", a_rx_empty);
      end
   endtask

   task automatic test_random_loop();
      logic [7:0] d;
      int         c;
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom_range(0, 255));
         write_a(d);
         c = 0;
         while (a_rx_empty === 1'b1 && c < 2500) begin
            @(negedge clk);
            c++;
         end
         n_checks++;
         if (a_rx_empty !== 1'b0 || a_rx_data !== d || {a_ovr, a_perr, a_ferr} !== 3'b000) begin
            n_fail++;
            $display("FAIL rand_loop_%0d: got empty=%b data=%h flags=%b want empty=0 data=%h flags=000",
                     k, a_rx_empty, a_rx_data, {a_ovr, a_perr, a_ferr}, d);
         end
         pop_a();
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      repeat (300) @(negedge clk);
      pop_a();
      n_checks++;
      if (a_rx_empty !== 1'b1) begin
         n_fail++; $display("FAIL rd_when_empty: got empty=%b want 1", a_rx_empty);
      end
   endtask

   task automatic test_frame_err();
      drive_frame(8'h3C, odd_par(8'h3C), 1'b0);
      n_checks++;
      if (b_rx_empty !== 1'b0 || b_rx_data !== 8'h3C) begin
         n_fail++; $display("FAIL frame_err_data: got empty=%b data=%h want empty=0 data=3c", b_rx_empty, b_rx_data);
      end
      n_checks++;
      if ({b_perr, b_ferr} !== 2'b01) begin
         n_fail++; $display("FAIL frame_err_flags: got perr/ferr=%b want 01", {b_perr, b_ferr});
      end
      pop_b();
      clr_b();
      n_checks++;
      if (b_ferr !== 1'b0 || b_rx_empty !== 1'b1) begin
         n_fail++; $display("FAIL frame_err_clear: got ferr=%b empty=%b want 0 1", b_ferr, b_rx_empty);
      end
   endtask

   task automatic test_parity_err();
      drive_frame(8'h0F, 1'b0, 1'b1);
      n_checks++;
      if (b_rx_empty !== 1'b0 || b_rx_data !== 8'h0F) begin
         n_fail++; $display("FAIL parity_err_data: got empty=%b data=%h want empty=0 data=0f", b_rx_empty, b_rx_data);
      end
      n_checks++;
      if ({b_perr, b_ferr} !== 2'b10) begin
         n_fail++; $display("FAIL parity_err_flags: got perr/ferr=%b want 10", {b_perr, b_ferr});
      end
      pop_b();
      clr_b();
   endtask

   task automatic test_glitch();
      @(negedge clk); b_rx = 1'b0;
      repeat (50) @(negedge clk);
      b_rx = 1'b1;
      repeat (400) @(negedge clk);
      n_checks++;
      if (b_rx_empty !== 1'b1 || {b_ovr, b_perr, b_ferr} !== 3'b000) begin
         n_fail++; $display("FAIL glitch_no_push: got empty=%b flags=%b want 1 000", b_rx_empty, {b_ovr, b_perr, b_ferr});
      end
      drive_frame(8'h5A, odd_par(8'h5A), 1'b1);
      n_checks++;
      if (b_rx_empty !== 1'b0 || b_rx_data !== 8'h5A || {b_perr, b_ferr} !== 2'b00) begin
         n_fail++; $display("FAIL glitch_recover: got empty=%b data=%h flags=%b want 0 5a 00",
                            b_rx_empty, b_rx_data, {b_perr, b_ferr});
      end
      pop_b();
   endtask

   task automatic test_random_rx();
      logic [7:0] d;
      logic       bad_par, stop_ok, pbit, exp_perr, exp_ferr;
      for (int k = 0; k < 6; k++) begin
         d        = 8'($urandom_range(0, 255));
         bad_par  = ($urandom_range(0, 3) == 0);
         stop_ok  = ($urandom_range(0, 3) != 0);
         pbit     = odd_par(d) ^ bad_par;
         exp_perr = (pbit != odd_par(d));
         exp_ferr = !stop_ok;
         drive_frame(d, pbit, stop_ok);
         n_checks++;
         if (b_rx_empty !== 1'b0 || b_rx_data !== d || {b_perr, b_ferr} !== {exp_perr, exp_ferr}) begin
            n_fail++;
            $display("FAIL rand_rx_%0d: got empty=%b data=%h perr/ferr=%b want empty=0 data=%h perr/ferr=%b",
                     k, b_rx_empty, b_rx_data, {b_perr, b_ferr}, d, {exp_perr, exp_ferr});
         end
         pop_b();
         clr_b();
      end
   endtask

   task automatic test_reset_mid_tx();
      int c, bad;
      write_a(8'h11);
      write_a(8'h22);
      write_a(8'h33);
      c = 0;
      while (a_done !== 1'b1 && c < 2500) begin
         @(negedge clk);
         c++;
      end
      c = 0;
      while (a_tx !== 1'b0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (a_tx !== 1'b0) begin
         n_fail++; $display("FAIL rst_second_frame_start: got tx=%b want 0", a_tx);
      end
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({a_tx, a_tx_empty, a_done, a_rx_empty} !== 4'b1101) begin
         n_fail++; $display("FAIL rst_mid_frame: got tx/txe/done/rxe=%b want 1101",
                            {a_tx, a_tx_empty, a_done, a_rx_empty});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         if (a_done !== 1'b0 || a_tx !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0 || a_rx_empty !== 1'b1) begin
         n_fail++; $display("FAIL rst_quiet_after: got activity=%0d rxe=%b want 0 1", bad, a_rx_empty);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      a_tx_wr   = 1'b0; a_tx_data = '0; a_rx_rd = 1'b0; a_clr = 1'b0;
      b_rx      = 1'b1; b_tx_wr   = 1'b0; b_tx_data = '0; b_rx_rd = 1'b0; b_clr = 1'b0;
      test_reset();
      test_loopback();
      test_overrun();
      test_random_loop();
      test_frame_err();
      test_parity_err();
      test_glitch();
      test_random_rx();
      test_reset_mid_tx();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
